reset_sequencer: RTL and testbench

Parametrised successor of the peripheral reset controller. It produces NUM_CHANNELS independent active-low peripheral resets, each with its own trigger or continuous mode, watchdog gating and programmable release delay, built on real cycle counters. Pin inputs are synchronised, faults are sticky and the alive heartbeat is runtime-configurable. It sits between the PS configuration registers and the DAC/ADC/RAM-writer reset inputs.

---
 rtl/reset_seq_pkg.sv | 19 +
 rtl/reset_seq_if.sv | 26 ++
 rtl/reset_seq_channel.sv | 84 ++++++++
 rtl/reset_sequencer.sv | 122 ++++++++++++
 tb/tb_reset_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared constants for the peripheral reset sequencer: channel FSM state codes
// and status-word bit positions.
package reset_seq_pkg;

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int unsigned STAT_ARESETN_LSB = 0;
  localparam int unsigned STAT_TRIG        = 8;
  localparam int unsigned STAT_WDG         = 9;
  localparam int unsigned STAT_INST        = 10;
  localparam int unsigned STAT_WDG_EXPIRED = 11;
  localparam int unsigned STAT_RESET_ACK   = 12;
  localparam int unsigned STAT_STICKY_LSB  = 16;
  localparam int unsigned STAT_MAX_CH      = 8;

endpackage

// File: rtl/reset_seq_if.sv
// Configuration bus from the PS register block into the reset sequencer.
interface reset_seq_if #(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned WDG_CNT_WIDTH   = 27,
  parameter int unsigned DELAY_WIDTH     = 24,
  parameter int unsigned ALIVE_CNT_WIDTH = 28
);
  logic [NUM_CHANNELS-1:0]             cfg_trig_mode;
  logic [NUM_CHANNELS-1:0]             cfg_wdg_en;
  logic                                cfg_instant_en;
  logic [WDG_CNT_WIDTH-1:0]            cfg_wdg_timeout;
  logic [NUM_CHANNELS*DELAY_WIDTH-1:0] cfg_release_delay;
  logic [ALIVE_CNT_WIDTH-1:0]          cfg_alive_low;
  logic [ALIVE_CNT_WIDTH-1:0]          cfg_alive_high;
  logic                                fault_clear;

  modport master (
    output cfg_trig_mode, cfg_wdg_en, cfg_instant_en, cfg_wdg_timeout,
           cfg_release_delay, cfg_alive_low, cfg_alive_high, fault_clear
  );

  modport slave (
    input  cfg_trig_mode, cfg_wdg_en, cfg_instant_en, cfg_wdg_timeout,
           cfg_release_delay, cfg_alive_low, cfg_alive_high, fault_clear
  );
endinterface

// File: rtl/reset_seq_channel.sv
// One reset channel: HOLD/DELAY/RUN/FAULT FSM with release-delay counter and sticky fault bit.
// RESET_SEQ_AUTO_RECOVER_EN: FAULT returns to HOLD as soon as kill drops.
module reset_seq_channel
  import reset_seq_pkg::*;
#(
  parameter int unsigned DELAY_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   peripheral_reset,
  input  logic                   cond,
  input  logic                   kill,
  input  logic                   fault_clear,
  input  logic [DELAY_WIDTH-1:0] delay,
  output logic                   run_c,
  output logic                   fault_c,
  output logic                   sticky
);

  logic [1:0]             state_q, state_d;
  logic [DELAY_WIDTH-1:0] dcnt_q, dcnt_d;
  logic                   sticky_q, sticky_d;

  always_ff @(posedge clk) begin
    if (peripheral_reset) begin
      state_q  <= ST_HOLD;
      dcnt_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    sticky_d = sticky_q;
`ifdef RESET_SEQ_AUTO_RECOVER_EN
    if (fault_clear) sticky_d = 1'b0;
`else
    if (fault_clear && !kill) sticky_d = 1'b0;
`endif
    case (state_q)
      ST_HOLD: begin
        if (cond && !kill) begin
          if (delay == '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DELAY;
            dcnt_d  = delay - DELAY_WIDTH'(1);
          end
        end
      end
      ST_DELAY: begin
        if (kill || !cond)      state_d = ST_HOLD;
        else if (dcnt_q == '0)  state_d = ST_RUN;
        else                    dcnt_d  = dcnt_q - DELAY_WIDTH'(1);
      end
      ST_RUN: begin
        // kill outranks a dropped trigger so the fault is always recorded
        if (kill) begin
          state_d  = ST_FAULT;
          sticky_d = 1'b1;
        end else if (!cond) begin
          state_d = ST_HOLD;
        end
      end
      ST_FAULT: begin
`ifdef RESET_SEQ_AUTO_RECOVER_EN
        if (!kill) state_d = ST_HOLD;
`else
        if (fault_clear && !kill) state_d = ST_HOLD;
`endif
      end
      default: state_d = ST_HOLD;
    endcase
  end

  assign run_c   = (state_q == ST_RUN);
  assign fault_c = (state_q == ST_FAULT);
  assign sticky  = sticky_q;

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel peripheral reset sequencer: pin synchronisers, watchdog, heartbeat, status.
// Channel fault recovery mode is selected by RESET_SEQ_AUTO_RECOVER_EN (see reset_seq_channel).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned WDG_CNT_WIDTH   = 27,
  parameter int unsigned DELAY_WIDTH     = 24,
  parameter int unsigned ALIVE_CNT_WIDTH = 28
) (
  input  logic                    clk,
  input  logic                    peripheral_reset,
  input  logic                    trigger_pin,
  input  logic                    watchdog_pin,
  input  logic                    instant_reset_pin,
  reset_seq_if.slave              cfg,
  output logic [NUM_CHANNELS-1:0] ch_aresetn,
  output logic                    reset_ack,
  output logic                    alive_signal,
  output logic [31:0]             status
);

  localparam int unsigned ASUM_W = ALIVE_CNT_WIDTH + 1;

  logic [SYNC_STAGES-1:0]     trig_sync_q, trig_sync_d;
  logic [SYNC_STAGES-1:0]     wdg_sync_q, wdg_sync_d;
  logic [SYNC_STAGES-1:0]     inst_sync_q, inst_sync_d;
  logic                       wdg_prev_q, wdg_prev_d;
  logic [WDG_CNT_WIDTH-1:0]   wdg_cnt_q, wdg_cnt_d;
  logic [ALIVE_CNT_WIDTH-1:0] acnt_q, acnt_d;
  logic                       alive_q, alive_d;

  logic                       trig_s, wdg_s, inst_s;
  logic                       wdg_expired_c;
  logic [ASUM_W-1:0]          alive_total_c, acnt_inc_c;
  logic [NUM_CHANNELS-1:0]    run_vec, fault_vec, sticky_vec;

  always_ff @(posedge clk) begin
    if (peripheral_reset) begin
      trig_sync_q <= '0;
      wdg_sync_q  <= '0;
      inst_sync_q <= '0;
      wdg_prev_q  <= 1'b0;
      wdg_cnt_q   <= '0;
      acnt_q      <= '0;
      alive_q     <= 1'b0;
    end else begin
      trig_sync_q <= trig_sync_d;
      wdg_sync_q  <= wdg_sync_d;
      inst_sync_q <= inst_sync_d;
      wdg_prev_q  <= wdg_prev_d;
      wdg_cnt_q   <= wdg_cnt_d;
      acnt_q      <= acnt_d;
      alive_q     <= alive_d;
    end
  end

  always_comb begin
    trig_sync_d = {trig_sync_q[SYNC_STAGES-2:0], trigger_pin};
    wdg_sync_d  = {wdg_sync_q[SYNC_STAGES-2:0], watchdog_pin};
    inst_sync_d = {inst_sync_q[SYNC_STAGES-2:0], instant_reset_pin};
  end

  assign trig_s = trig_sync_q[SYNC_STAGES-1];
  assign wdg_s  = wdg_sync_q[SYNC_STAGES-1];
  assign inst_s = inst_sync_q[SYNC_STAGES-1];

  // Watchdog: any host toggle restarts the count, otherwise saturate
  always_comb begin
    wdg_prev_d = wdg_s;
    wdg_cnt_d  = wdg_cnt_q;
    if (wdg_s != wdg_prev_q)  wdg_cnt_d = '0;
    else if (wdg_cnt_q != '1) wdg_cnt_d = wdg_cnt_q + WDG_CNT_WIDTH'(1);
  end

  assign wdg_expired_c = (cfg.cfg_wdg_timeout != '0) && (wdg_cnt_q >= cfg.cfg_wdg_timeout);

  // Heartbeat: compare in one extra bit so low+high cannot overflow; a shrunk period wraps at once
  always_comb begin
    alive_total_c = {1'b0, cfg.cfg_alive_low} + {1'b0, cfg.cfg_alive_high};
    acnt_inc_c    = {1'b0, acnt_q} + ASUM_W'(1);
    acnt_d        = (acnt_inc_c >= alive_total_c) ? '0 : acnt_inc_c[ALIVE_CNT_WIDTH-1:0];
    alive_d       = (alive_total_c != '0) && (acnt_q >= cfg.cfg_alive_low);
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic cond_c, kill_c;
    assign cond_c = cfg.cfg_trig_mode[i] ? trig_s : 1'b1;
    assign kill_c = (cfg.cfg_instant_en & inst_s) | (cfg.cfg_wdg_en[i] & wdg_expired_c);

    reset_seq_channel #(
      .DELAY_WIDTH (DELAY_WIDTH)
    ) u_channel (
      .clk              (clk),
      .peripheral_reset (peripheral_reset),
      .cond             (cond_c),
      .kill             (kill_c),
      .fault_clear      (cfg.fault_clear),
      .delay            (cfg.cfg_release_delay[i*DELAY_WIDTH +: DELAY_WIDTH]),
      .run_c            (run_vec[i]),
      .fault_c          (fault_vec[i]),
      .sticky           (sticky_vec[i])
    );
  end

  assign ch_aresetn   = run_vec;
  assign reset_ack    = |fault_vec;
  assign alive_signal = alive_q;

  always_comb begin
    status = '0;
    status[STAT_ARESETN_LSB +: NUM_CHANNELS] = run_vec;
    status[STAT_TRIG]                        = trig_s;
    status[STAT_WDG]                         = wdg_s;
    status[STAT_INST]                        = inst_s;
    status[STAT_WDG_EXPIRED]                 = wdg_expired_c;
    status[STAT_RESET_ACK]                   = reset_ack;
    status[STAT_STICKY_LSB +: NUM_CHANNELS]  = sticky_vec;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (default build, 4 channels, 2 sync stages).
module tb_reset_sequencer;

  localparam int unsigned NC = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned WW = 27;
  localparam int unsigned DW = 24;
  localparam int unsigned AW = 28;

  logic          clk = 1'b0;
  logic          peripheral_reset;
  logic          trigger_pin;
  logic          watchdog_pin;
  logic          instant_reset_pin;
  logic [NC-1:0] ch_aresetn;
  logic          reset_ack;
  logic          alive_signal;
  logic [31:0]   status;

  int n_checks = 0;
  int n_fail   = 0;

  reset_seq_if #(.NUM_CHANNELS(NC), .WDG_CNT_WIDTH(WW), .DELAY_WIDTH(DW), .ALIVE_CNT_WIDTH(AW)) cfg_bus ();

  reset_sequencer #(
    .NUM_CHANNELS(NC), .SYNC_STAGES(SS), .WDG_CNT_WIDTH(WW),
    .DELAY_WIDTH(DW), .ALIVE_CNT_WIDTH(AW)
  ) dut (
    .clk               (clk),
    .peripheral_reset  (peripheral_reset),
    .trigger_pin       (trigger_pin),
    .watchdog_pin      (watchdog_pin),
    .instant_reset_pin (instant_reset_pin),
    .cfg               (cfg_bus.slave),
    .ch_aresetn        (ch_aresetn),
    .reset_ack         (reset_ack),
    .alive_signal      (alive_signal),
    .status            (status)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ticks until ch_aresetn[ch] equals val; returns the tick count or -1 if max is exceeded.
  task automatic ticks_until(input int ch, input logic val, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick(1);
      if (ch_aresetn[ch] === val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    cfg_bus.fault_clear = 1'b1;
    tick(1);
    cfg_bus.fault_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          n;
    int          hi;
    logic [19:0] got20, exp20;
    logic [8:0]  got9;

    peripheral_reset  = 1'b1;
    trigger_pin       = 1'b0;
    watchdog_pin      = 1'b0;
    instant_reset_pin = 1'b0;
    cfg_bus.cfg_trig_mode     = 4'b0010;
    cfg_bus.cfg_wdg_en        = 4'b0100;
    cfg_bus.cfg_instant_en    = 1'b0;
    cfg_bus.cfg_wdg_timeout   = '0;
    cfg_bus.cfg_release_delay = {24'd0, 24'd0, 24'd5, 24'd10};
    cfg_bus.cfg_alive_low     = 28'd7;
    cfg_bus.cfg_alive_high    = 28'd3;
    cfg_bus.fault_clear       = 1'b0;

    tick(3);
    check_eq("rst_aresetn", 32'(ch_aresetn), 32'h0);
    check_eq("rst_ack", 32'(reset_ack), 32'h0);
    check_eq("rst_alive", 32'(alive_signal), 32'h0);
    check_eq("rst_status", status, 32'h0);

    // continuous channels leave HOLD on the first edge after reset release
    peripheral_reset = 1'b0;
    tick(1);
    check_eq("t1_delay0_channels", 32'(ch_aresetn), 32'hC);
    ticks_until(0, 1'b1, 40, n);
    check_eq("t1_ch0_rise_delay10", 32'(n + 1), 32'd11);

    // short trigger pulse must not let ch1 finish its delay
    trigger_pin = 1'b1;
    tick(4);
    trigger_pin = 1'b0;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (ch_aresetn[1]) hi++;
    end
    check_eq("t2_short_pulse", 32'(hi), 32'd0);
    trigger_pin = 1'b1;
    ticks_until(1, 1'b1, 30, n);
    check_eq("t2_trig_rise", 32'(n), 32'd8);
    check_eq("t2_trig_s", 32'(status[8]), 32'd1);
    trigger_pin = 1'b0;
    ticks_until(1, 1'b0, 30, n);
    check_eq("t2_trig_fall", 32'(n), 32'd3);

    // watchdog gating on ch2
    cfg_bus.cfg_wdg_timeout = 27'd1000;
    for (int k = 0; k < 3; k++) begin
      watchdog_pin = ~watchdog_pin;
      tick(500);
      check_eq("t3_wdg_kept_alive", 32'(ch_aresetn[2]), 32'd1);
    end
    watchdog_pin = ~watchdog_pin;
    ticks_until(2, 1'b0, 1100, n);
    check_eq("t3_wdg_expiry", 32'(n), 32'd1004);
    check_eq("t3_sticky2", 32'(status[18]), 32'd1);
    check_eq("t3_ack", 32'(reset_ack), 32'd1);
    check_eq("t3_expired_flag", 32'(status[11]), 32'd1);
    watchdog_pin = ~watchdog_pin;
    tick(5);
    check_eq("t3_expired_cleared", 32'(status[11]), 32'd0);
    check_eq("t3_stays_fault", 32'(ch_aresetn), 32'h9);
    check_eq("t3_ack_held", 32'(reset_ack), 32'd1);
    pulse_clear();
    check_eq("t3_sticky_clr", 32'(status[23:16]), 32'h0);
    check_eq("t3_ack_clr", 32'(reset_ack), 32'd0);
    tick(1);
    check_eq("t3_ch2_back", 32'(ch_aresetn), 32'hD);
    cfg_bus.cfg_wdg_timeout = '0;

    // instant reset, fault_clear ignored while the pin is held
    trigger_pin = 1'b1;
    tick(10);
    check_eq("t4_all_run", 32'(ch_aresetn), 32'hF);
    cfg_bus.cfg_instant_en = 1'b1;
    instant_reset_pin = 1'b1;
    ticks_until(0, 1'b0, 10, n);
    check_eq("t4_instant_latency", 32'(n), 32'd3);
    check_eq("t4_all_low", 32'(ch_aresetn), 32'h0);
    check_eq("t4_sticky_all", 32'(status[23:16]), 32'h0F);
    check_eq("t4_ack", 32'(reset_ack), 32'd1);
    pulse_clear();
    tick(3);
    check_eq("t4_clr_ignored", 32'(ch_aresetn), 32'h0);
    check_eq("t4_clr_ignored_ack", 32'(reset_ack), 32'd1);
    check_eq("t4_clr_ignored_sticky", 32'(status[23:16]), 32'h0F);
    instant_reset_pin = 1'b0;
    tick(4);
    check_eq("t4_no_auto_recover", 32'(ch_aresetn), 32'h0);
    pulse_clear();
    check_eq("t4_ack_clr", 32'(reset_ack), 32'd0);
    check_eq("t4_sticky_clr", 32'(status[23:16]), 32'h0);
    tick(1);
    check_eq("t4_rel_delay0", 32'(ch_aresetn), 32'hC);
    tick(5);
    check_eq("t4_rel_delay5", 32'(ch_aresetn), 32'hE);
    tick(5);
    check_eq("t4_rel_delay10", 32'(ch_aresetn), 32'hF);
    cfg_bus.cfg_instant_en = 1'b0;

    // heartbeat low=7 high=3 from a fresh reset
    peripheral_reset = 1'b1;
    tick(2);
    peripheral_reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      got20[k-1] = alive_signal;
      exp20[k-1] = (((k - 1) % 10) >= 7);
    end
    check_eq("t5_period10", 32'(got20), 32'(exp20));

    // shrink to low=2 high=1 while acnt is 8
    peripheral_reset = 1'b1;
    tick(2);
    peripheral_reset = 1'b0;
    tick(8);
    cfg_bus.cfg_alive_low  = 28'd2;
    cfg_bus.cfg_alive_high = 28'd1;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      got9[k] = alive_signal;
    end
    check_eq("t5_shrink_period3", 32'(got9), 32'h049);

    cfg_bus.cfg_alive_low  = '0;
    cfg_bus.cfg_alive_high = '0;
    tick(2);
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (alive_signal) hi++;
    end
    check_eq("t5_zero_period", 32'(hi), 32'd0);

    // reset while ch0 is in DELAY and ch3 is in FAULT
    cfg_bus.cfg_alive_low     = 28'd7;
    cfg_bus.cfg_alive_high    = 28'd3;
    cfg_bus.cfg_trig_mode     = 4'b0000;
    cfg_bus.cfg_wdg_en        = 4'b1000;
    cfg_bus.cfg_wdg_timeout   = 27'd5;
    cfg_bus.cfg_release_delay = {24'd0, 24'd0, 24'd0, 24'd20};
    watchdog_pin      = 1'b0;
    peripheral_reset  = 1'b1;
    tick(2);
    peripheral_reset = 1'b0;
    tick(8);
    check_eq("t6_pre_aresetn", 32'(ch_aresetn), 32'h6);
    check_eq("t6_pre_ack", 32'(reset_ack), 32'd1);
    check_eq("t6_pre_sticky3", 32'(status[19]), 32'd1);
    peripheral_reset = 1'b1;
    tick(1);
    check_eq("t6_aresetn", 32'(ch_aresetn), 32'h0);
    check_eq("t6_ack", 32'(reset_ack), 32'd0);
    check_eq("t6_alive", 32'(alive_signal), 32'd0);
    check_eq("t6_status", status, 32'h0);
    cfg_bus.cfg_wdg_en      = '0;
    cfg_bus.cfg_wdg_timeout = '0;
    peripheral_reset = 1'b0;
    tick(1);
    check_eq("t6_from_hold", 32'(ch_aresetn), 32'hE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
